// File: rtl/fp_mac_seq.sv
// Sequencer that streams K weight/data pairs from two SRAMs into an external MAC per output and collects each result.
// Latency: K issue cycles, then the MAC latency (at most 16 wait cycles), one OUT cycle minimum and a 2-cycle gap per output.
// Backpressure: a result is held in OUT until res_rdy; no further SRAM reads are issued while a result is pending.
module fp_mac_seq #(
    parameter int WIDTH = 8,
    parameter int K     = 4,
    parameter int NW    = 6,
    parameter int AW    = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [NW-1:0]    n_out,
    output logic             busy,
    output logic             done,
    output logic             rd_en,
    output logic [AW-1:0]    w_addr,
    output logic [AW-1:0]    d_addr,
    input  logic [WIDTH-1:0] w_rdata,
    input  logic [WIDTH-1:0] d_rdata,
    output logic             mac_vld_i,
    output logic [WIDTH-1:0] mac_win,
    output logic [WIDTH-1:0] mac_din,
    input  logic [WIDTH-1:0] mac_acc_o,
    input  logic             mac_vld_o,
    output logic             res_vld,
    input  logic             res_rdy,
    output logic [WIDTH-1:0] res_data,
    output logic [NW-1:0]    res_idx,
    output logic             err
);
    // k counter must hold 0..K-1; keep at least one bit so K=1 still elaborates.
    localparam int              KW     = (K > 1) ? $clog2(K) : 1;
    localparam int              TW     = 4;
    localparam logic [KW-1:0]   K_LAST = KW'(K - 1);
    localparam logic [AW-1:0]   K_AW   = AW'(K);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        OUT   = 3'd3,
        GAP   = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [NW-1:0]    nout_q, nout_d;
    logic [NW-1:0]    idx_q, idx_d;
    logic [KW-1:0]    k_q, k_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic             gap_q, gap_d;
    logic             res_vld_q, res_vld_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic [NW-1:0]    res_idx_q, res_idx_d;
    logic             err_q, err_d;

    // Read-data alignment pipeline.
    logic             rd_q;
    logic             mac_vld_q;
    logic [WIDTH-1:0] mac_win_q;
    logic [WIDTH-1:0] mac_din_q;

    // Next-state and datapath update for the job sequencer.
    always_comb begin
        state_d    = state_q;
        nout_d     = nout_q;
        idx_d      = idx_q;
        k_d        = k_q;
        tmo_d      = tmo_q;
        gap_d      = gap_q;
        res_vld_d  = res_vld_q;
        res_data_d = res_data_q;
        res_idx_d  = res_idx_q;
        err_d      = err_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    err_d = 1'b0;
                    idx_d = '0;
                    k_d   = '0;
                    if (n_out != '0) begin
                        nout_d  = n_out;
                        state_d = ISSUE;
                    end else begin
                        state_d = DONE;
                    end
                end
            end

            ISSUE: begin
                // Timeout counter is armed here so WAIT always starts from zero.
                tmo_d = '0;
                if (k_q == K_LAST) begin
                    k_d     = '0;
                    state_d = WAIT;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end

            WAIT: begin
                if (mac_vld_o) begin
                    res_data_d = mac_acc_o;
                    res_idx_d  = idx_q;
                    res_vld_d  = 1'b1;
                    state_d    = OUT;
                end else if (tmo_q == '1) begin
                    // 16th WAIT cycle with no MAC strobe: deliver a zero result and flag it.
                    err_d      = 1'b1;
                    res_data_d = '0;
                    res_idx_d  = idx_q;
                    res_vld_d  = 1'b1;
                    state_d    = OUT;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end

            OUT: begin
                // res_vld is high for the whole of OUT, so res_rdy alone marks the transfer.
                if (res_rdy) begin
                    res_vld_d = 1'b0;
                    idx_d     = idx_q + NW'(1);
                    gap_d     = 1'b0;
                    state_d   = GAP;
                end
            end

            GAP: begin
                // Two quiet cycles let the MAC's valid history drain and its accumulator clear.
                if (gap_q) begin
                    gap_d   = 1'b0;
                    state_d = (idx_q < nout_q) ? ISSUE : DONE;
                end else begin
                    gap_d = 1'b1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            nout_q     <= '0;
            idx_q      <= '0;
            k_q        <= '0;
            tmo_q      <= '0;
            gap_q      <= 1'b0;
            res_vld_q  <= 1'b0;
            res_data_q <= '0;
            res_idx_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            nout_q     <= nout_d;
            idx_q      <= idx_d;
            k_q        <= k_d;
            tmo_q      <= tmo_d;
            gap_q      <= gap_d;
            res_vld_q  <= res_vld_d;
            res_data_q <= res_data_d;
            res_idx_q  <= res_idx_d;
            err_q      <= err_d;
        end
    end

    // Register the SRAM read data and the matching valid. Read data arrives the
    // cycle after rd_en, so the valid is carried one extra stage (rd_q) to line it
    // up with the captured operands. The last two MAC beats therefore land in the
    // first WAIT cycles; nothing new is issued once ISSUE ends.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_q      <= 1'b0;
            mac_vld_q <= 1'b0;
            mac_win_q <= '0;
            mac_din_q <= '0;
        end else begin
            rd_q      <= rd_en;
            mac_vld_q <= rd_q;
            mac_win_q <= rd_q ? w_rdata : '0;
            mac_din_q <= rd_q ? d_rdata : '0;
        end
    end

    // Status, SRAM address and result outputs. Addresses are zero outside ISSUE.
    // Address width must cover NW + clog2(K) bits so idx*K + k never wraps.
    always_comb begin
        busy   = (state_q != IDLE);
        done   = (state_q == DONE);
        rd_en  = (state_q == ISSUE);
        w_addr = '0;
        d_addr = '0;
        if (state_q == ISSUE) begin
            w_addr = AW'(idx_q) * K_AW + AW'(k_q);
            d_addr = AW'(k_q);
        end
    end

    assign mac_vld_i = mac_vld_q;
    assign mac_win   = mac_win_q;
    assign mac_din   = mac_din_q;
    assign res_vld   = res_vld_q;
    assign res_data  = res_data_q;
    assign res_idx   = res_idx_q;
    assign err       = err_q;

endmodule

// File: tb/tb_fp_mac_seq.sv
// Bench for fp_mac_seq: SRAM and MAC models plus a scoreboard monitor.
// Expected results come from the memory contents (sum of w^d per output, or 0 on timeout).
// All DUT outputs are sampled on the falling edge; stimulus changes 1 time unit after the rising edge.
module tb_fp_mac_seq;
    localparam int WIDTH = 8;
    localparam int K     = 4;
    localparam int NW    = 6;
    localparam int AW    = 8;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             start = 1'b0;
    logic [NW-1:0]    n_out = '0;
    logic             busy, done, rd_en;
    logic [AW-1:0]    w_addr, d_addr;
    logic [WIDTH-1:0] w_rdata = '0;
    logic [WIDTH-1:0] d_rdata = '0;
    logic             mac_vld_i;
    logic [WIDTH-1:0] mac_win, mac_din;
    logic [WIDTH-1:0] mac_acc_m = '0;
    logic             mac_vld_m = 1'b0;
    logic             spur_vld = 1'b0;
    logic [WIDTH-1:0] mac_acc_o;
    logic             mac_vld_o;
    logic             res_vld;
    logic             res_rdy = 1'b1;
    logic [WIDTH-1:0] res_data;
    logic [NW-1:0]    res_idx;
    logic             err;

    // A spurious MAC strobe can be injected on top of the model's output.
    assign mac_vld_o = mac_vld_m | spur_vld;
    assign mac_acc_o = spur_vld ? 8'hA5 : mac_acc_m;

    fp_mac_seq #(.WIDTH(WIDTH), .K(K), .NW(NW), .AW(AW)) dut (
        .clk(clk), .rstn(rstn), .start(start), .n_out(n_out),
        .busy(busy), .done(done), .rd_en(rd_en), .w_addr(w_addr), .d_addr(d_addr),
        .w_rdata(w_rdata), .d_rdata(d_rdata),
        .mac_vld_i(mac_vld_i), .mac_win(mac_win), .mac_din(mac_din),
        .mac_acc_o(mac_acc_o), .mac_vld_o(mac_vld_o),
        .res_vld(res_vld), .res_rdy(res_rdy), .res_data(res_data), .res_idx(res_idx),
        .err(err)
    );

    always #5 clk = ~clk;

    logic [7:0] wmem [0:255];
    logic [7:0] dmem [0:255];
    bit         mac_en = 1'b1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // SRAM model: data for the address presented with rd_en shows up the next cycle.
    logic          rd_p = 1'b0;
    logic [AW-1:0] wa_p = '0;
    logic [AW-1:0] da_p = '0;
    always @(negedge clk) begin
        if (rd_p) begin
            w_rdata = wmem[wa_p];
            d_rdata = dmem[da_p];
        end else begin
            w_rdata = 8'hEE;
            d_rdata = 8'hEE;
        end
        rd_p = rd_en;
        wa_p = w_addr;
        da_p = d_addr;
    end

    // MAC model: sums w^d over K valid beats, answers 11 cycles after the last beat.
    int         macc = 0;
    int         mn = 0;
    int         pend = 0;
    logic [7:0] mres = '0;
    always @(negedge clk) begin
        mac_vld_m = 1'b0;
        if (!rstn) begin
            macc = 0;
            mn   = 0;
            pend = 0;
        end else begin
            if (pend > 0) begin
                pend--;
                if (pend == 0 && mac_en) begin
                    mac_vld_m = 1'b1;
                    mac_acc_m = mres;
                end
            end
            if (mac_vld_i) begin
                macc += int'(mac_win ^ mac_din);
                mn++;
                if (mn == K) begin
                    pend = 11;
                    mres = 8'(macc);
                    macc = 0;
                    mn   = 0;
                end
            end
        end
    end

    // Scoreboard / protocol monitor.
    int            cyc = 0, rd_cnt = 0, vld_tot = 0, run = 0, idle = 0, since_rd = 0;
    int            job_n = 0, start_cyc = 0, done_cnt = 0, xfer_cnt = 0, s = 0;
    bit            had_run = 0, prev_vld = 0, prev_rdy = 0, prev_err = 0, prev_done = 0;
    logic [7:0]    prev_data = '0, last_data = '0;
    logic [NW-1:0] prev_idx = '0, last_idx = '0;
    logic [7:0]    exp_d[$];
    logic [NW-1:0] exp_i[$];
    bit            exp_e[$];
    int            waddr_log[$];
    int            idx_log[$];

    always @(negedge clk) begin
        cyc++;
        if (!rstn) begin
            exp_d.delete(); exp_i.delete(); exp_e.delete();
            run = 0; idle = 0; had_run = 0;
            prev_vld = 0; prev_err = 0; prev_done = 0;
        end else begin
            if (start && !busy) begin
                job_n = int'(n_out); start_cyc = cyc;
                rd_cnt = 0; vld_tot = 0; run = 0; idle = 0; had_run = 0;
                waddr_log.delete(); idx_log.delete();
                for (int i = 0; i < job_n; i++) begin
                    s = 0;
                    for (int k = 0; k < K; k++) s += int'(wmem[i*K+k] ^ dmem[k]);
                    exp_d.push_back(mac_en ? 8'(s) : 8'h00);
                    exp_i.push_back(NW'(i));
                    exp_e.push_back(!mac_en);
                end
            end
            if (rd_en) begin
                chk("w_addr", 32'(w_addr), rd_cnt);
                chk("d_addr", 32'(d_addr), rd_cnt % K);
                chk("rd_en_while_res_vld", 32'(res_vld), 0);
                waddr_log.push_back(int'(w_addr));
                rd_cnt++;
                since_rd = 0;
            end else begin
                since_rd++;
            end
            if (mac_vld_i) begin
                if (run == 0 && had_run) chk("burst_gap_ge2", 32'(idle >= 2), 1);
                run++; vld_tot++; idle = 0;
            end else begin
                if (run > 0) begin
                    chk("burst_len", run, K);
                    run = 0; had_run = 1;
                end
                idle++;
            end
            if (prev_vld && !prev_rdy) begin
                chk("hold_vld", 32'(res_vld), 1);
                chk("hold_data", 32'(res_data), 32'(prev_data));
                chk("hold_idx", 32'(res_idx), 32'(prev_idx));
            end
            if (res_vld && res_rdy) begin
                if (exp_d.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    chk("res_data", 32'(res_data), 32'(exp_d.pop_front()));
                    chk("res_idx", 32'(res_idx), 32'(exp_i.pop_front()));
                    chk("err_at_xfer", 32'(err), 32'(exp_e.pop_front()));
                end
                last_data = res_data; last_idx = res_idx;
                idx_log.push_back(int'(res_idx));
                xfer_cnt++;
            end
            if (err && !prev_err) chk("err_after_16_wait", since_rd, 17);
            if (done) begin
                done_cnt++;
                chk("done_single_cycle", 32'(prev_done), 0);
                chk("done_all_results", exp_d.size(), 0);
                chk("done_rd_count", rd_cnt, job_n * K);
                chk("done_vld_count", vld_tot, job_n * K);
                if (job_n == 0)
                    chk("zero_job_done_latency", 32'((cyc - start_cyc) >= 1 && (cyc - start_cyc) <= 2), 1);
            end
            prev_vld = res_vld; prev_rdy = res_rdy; prev_data = res_data;
            prev_idx = res_idx; prev_err = err; prev_done = done;
        end
    end

    task automatic do_start(input int n);
        @(posedge clk); #1;
        start = 1'b1;
        n_out = NW'(n);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound, input string name);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < bound; i++) begin
            @(posedge clk);
            if (done_cnt != d0) break;
        end
        chk({name, "_done_seen"}, 32'(done_cnt != d0), 1);
    endtask

    // sel 0 waits for res_vld, sel 1 for rd_en.
    task automatic wait_sig(input int sel, input int bound, input string name);
        bit seen;
        seen = 0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            seen = (sel == 0) ? res_vld : rd_en;
        end
        chk(name, 32'(seen), 1);
    endtask

    initial begin
        int d0, x0;
        for (int i = 0; i < 256; i++) begin
            wmem[i] = 8'h00;
            dmem[i] = 8'h00;
        end
        wmem[0] = 8'h10; wmem[1] = 8'h10; wmem[2] = 8'h10; wmem[3] = 8'h0C;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctrl", 32'({busy, done, rd_en, mac_vld_i, res_vld, err}), 0);
        chk("rst_addr", 32'({w_addr, d_addr}), 0);
        chk("rst_mac_ops", 32'({mac_win, mac_din}), 0);
        chk("rst_res", 32'({res_data, res_idx}), 0);
        rstn = 1'b1;

        // Single output, MAC answers 0x3C.
        d0 = done_cnt;
        do_start(1);
        wait_done(200, "t1");
        repeat (5) @(posedge clk);
        chk("t1_res_data", 32'(last_data), 32'h3C);
        chk("t1_res_idx", 32'(last_idx), 0);
        chk("t1_done_once", done_cnt - d0, 1);
        chk("t1_vld_cycles", vld_tot, 4);
        chk("t1_no_err", 32'(err), 0);

        // Three outputs, res_rdy always high.
        for (int i = 0; i < 256; i++) begin
            wmem[i] = 8'(i * 7 + 3);
            dmem[i] = 8'(i * 13 + 5);
        end
        do_start(3);
        wait_done(400, "t2");
        chk("t2_waddr_cnt", waddr_log.size(), 12);
        chk("t2_waddr_4", waddr_log[4], 4);
        chk("t2_waddr_11", waddr_log[11], 11);
        chk("t2_idx_seq", 32'({idx_log[0][7:0], idx_log[1][7:0], idx_log[2][7:0]}), 32'h000102);
        chk("t2_last_data", 32'(last_data), 32'h60);

        // Backpressure: hold res_rdy low in OUT, with a stray MAC strobe.
        res_rdy = 1'b0;
        do_start(2);
        wait_sig(0, 100, "t3_res_vld_seen");
        @(negedge clk); spur_vld = 1'b1;
        @(negedge clk); spur_vld = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("t3_no_new_rd", rd_cnt, 4);
        chk("t3_vld_held", 32'(res_vld), 1);
        chk("t3_data_held", 32'(res_data), 32'h60);
        res_rdy = 1'b1;
        wait_done(300, "t3");

        // MAC never answers: timeout path.
        mac_en = 1'b0;
        do_start(2);
        wait_done(400, "t4");
        chk("t4_err", 32'(err), 1);
        chk("t4_res_zero", 32'(last_data), 0);
        mac_en = 1'b1;
        do_start(1);
        repeat (2) @(posedge clk);
        #1;
        chk("t4_err_cleared", 32'(err), 0);
        wait_done(200, "t4b");

        // Zero-length job, then a start issued while busy.
        d0 = done_cnt;
        do_start(0);
        wait_done(10, "t5a");
        repeat (3) @(posedge clk);
        chk("t5_zero_no_rd", rd_cnt, 0);
        x0 = xfer_cnt;
        do_start(2);
        repeat (3) @(posedge clk);
        do_start(5);
        wait_done(500, "t5b");
        repeat (5) @(posedge clk);
        chk("t5_done_cnt", done_cnt - d0, 2);
        chk("t5_xfers", xfer_cnt - x0, 2);

        // Reset in the middle of ISSUE.
        do_start(3);
        wait_sig(1, 20, "t6_rd_seen");
        @(posedge clk); #3;
        rstn = 1'b0;
        #1;
        chk("t6_rst_ctrl", 32'({busy, done, rd_en, mac_vld_i, res_vld, err}), 0);
        chk("t6_rst_bus", 32'({w_addr, d_addr, res_idx}), 0);
        chk("t6_rst_data", 32'({mac_win, mac_din, res_data}), 0);
        d0 = done_cnt;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (30) @(posedge clk);
        chk("t6_no_done", done_cnt - d0, 0);
        do_start(1);
        wait_done(200, "t6");
        chk("t6_res_data", 32'(last_data), 32'h60);
        chk("t6_res_idx", 32'(last_idx), 0);

        // Largest job: no index or address wrap.
        x0 = xfer_cnt;
        do_start(63);
        wait_done(3000, "t7");
        chk("t7_xfers", xfer_cnt - x0, 63);
        chk("t7_last_idx", 32'(last_idx), 62);
        chk("t7_waddr_cnt", waddr_log.size(), 252);
        chk("t7_waddr_last", waddr_log[251], 251);

        repeat (5) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fp_mac_seq.md
FP_MAC_SEQ -- requirements
Module: fp_mac_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the FP word width passed to the MAC.
REQ-002 SHALL have parameter K, default 4, the dot-product length (MAC accumulation count); K >= 1.
REQ-003 SHALL have parameter NW, default 6, the width of the output-count and output-index fields.
REQ-004 SHALL have parameter AW, default 8, the SRAM address width; AW >= NW + clog2(K) is required.
REQ-005 Ports (name  direction  width  meaning):
- clk  in  1  single clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle job request, accepted only in IDLE.
- n_out  in  NW  number of dot products in the job, sampled at start; 0 means no work.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at job completion.
- rd_en  out  1  read strobe to both SRAMs.
- w_addr  out  AW  weight SRAM address.
- d_addr  out  AW  data SRAM address.
- w_rdata  in  WIDTH  weight read data, valid one cycle after rd_en.
- d_rdata  in  WIDTH  data read data, valid one cycle after rd_en.
- mac_vld_i  out  1  MAC input valid.
- mac_win  out  WIDTH  MAC weight operand.
- mac_din  out  WIDTH  MAC data operand.
- mac_acc_o  in  WIDTH  MAC result.
- mac_vld_o  in  1  MAC result strobe, one cycle wide.
- res_vld  out  1  result valid.
- res_rdy  in  1  result accept.
- res_data  out  WIDTH  captured MAC result.
- res_idx  out  NW  output index of res_data.
- err  out  1  sticky MAC timeout flag, cleared by start.

Function
REQ-006 SHALL use the FSM states IDLE, ISSUE, WAIT, OUT, GAP and DONE.
REQ-007 IDLE with start=1 and n_out>0 SHALL latch n_out, clear idx and err, and go to ISSUE.
REQ-008 IDLE with start=1 and n_out=0 SHALL go to DONE; start outside IDLE SHALL be ignored.
REQ-009 ISSUE SHALL last exactly K cycles, with k = 0..K-1:
- rd_en=1.
- w_addr = idx*K + k.
- d_addr = k.
REQ-010 mac_vld_i, mac_win and mac_din SHALL be rd_en, w_rdata and d_rdata delayed one cycle, so the MAC sees exactly K consecutive valid cycles per output.
REQ-011 After ISSUE the FSM SHALL enter WAIT, hold mac_vld_i low, and start a timeout counter.
REQ-012 WAIT SHALL end on mac_vld_o=1:
- res_data <= mac_acc_o, res_idx <= idx, res_vld <= 1.
- go to OUT.
REQ-013 On timeout (16 cycles in WAIT without mac_vld_o) the FSM SHALL set err=1, load res_data=0, and go to OUT.
REQ-014 OUT SHALL hold res_vld, res_data and res_idx stable until res_rdy=1; the transfer occurs on a cycle with res_vld & res_rdy.
REQ-015 On transfer in OUT the block SHALL clear res_vld, increment idx, and enter GAP.
REQ-016 GAP SHALL hold mac_vld_i low for 2 cycles so the MAC's valid history empties and its accumulator clears.
REQ-017 After GAP the FSM SHALL go to ISSUE if idx < n_out, else to DONE.
REQ-018 DONE SHALL pulse done=1 for one cycle, then go to IDLE.
REQ-019 mac_vld_o outside WAIT SHALL be ignored and SHALL NOT alter res_data.
REQ-020 res_rdy held high SHALL let the transfer occur on the first OUT cycle.
REQ-021 With n_out equal to 2^NW-1, idx and address arithmetic SHALL NOT wrap during the job.

Reset
REQ-022 On rstn=0, asynchronously:
- state=IDLE.
- busy, done, rd_en, mac_vld_i, res_vld and err = 0.
- w_addr, d_addr, mac_win, mac_din, res_data, res_idx and idx = 0.
REQ-023 Reset asserted mid-job SHALL abandon the job with no done pulse; the first start after reset release SHALL run normally.

Verification
REQ-024 K=4, n_out=1, with a MAC model returning 8'h3C eleven cycles after the last mac_vld_i:
- mac_vld_i is high exactly 4 cycles with d_addr 0..3.
- res_data=8'h3C and res_idx=0.
- done pulses once.
REQ-025 n_out=3 with res_rdy always 1:
- w_addr sequences 0..3, 4..7, 8..11.
- res_idx sequences 0, 1, 2.
- at least 2 idle mac_vld_i cycles between bursts.
REQ-026 res_rdy low for 5 cycles in OUT: res_vld and res_data stay stable, and no new rd_en occurs until acceptance.
REQ-027 The MAC never asserts mac_vld_o: err=1 after 16 WAIT cycles, res_data=0 is delivered, and the job still completes with done.
REQ-028 start with n_out=0: done two cycles later and no rd_en; a start issued while busy is ignored.
REQ-029 rstn pulsed low during ISSUE: all outputs are 0 immediately; a new start with n_out=1 then completes correctly.
